// File: rtl/cpu_pkg.sv
// Shared fetch-path parameters and the fetch FSM state encoding.
// Fetch modules take their widths and reset address from here by default.
package cpu_pkg;
    localparam int N = 32;
    localparam int M = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/pc_counter.sv
// Program counter: a redirect load takes priority over the +1 step, and the increment wraps at 2^M.
// Updates on the clock edge after load/inc; there is no backpressure, so the owner gates inc/load.
module pc_counter #(
    parameter int M = cpu_pkg::M,
    parameter logic [M-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [M-1:0] target,
    output logic [M-1:0] pc
);
    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ONE;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch: request a word, hold it for the decoder, honour redirects and halts.
// instr_valid rises one cycle after imem_ready. The decoder stalls fetch by withholding instr_ack.
module fetch_unit #(
    parameter int N = cpu_pkg::N,
    parameter int M = cpu_pkg::M,
    parameter logic [M-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [M-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] instr,
    output logic         instr_valid,
    output logic [M-1:0] instr_pc,
    input  logic         instr_ack,
    input  logic         redirect_valid,
    input  logic [M-1:0] redirect_target,
    input  logic         halt_in,
    output logic         halted,
    output logic [31:0]  retired_count
);
    import cpu_pkg::fetch_state_t;
    import cpu_pkg::FETCH;
    import cpu_pkg::HOLD;
    import cpu_pkg::HALT;

    fetch_state_t   state;
    fetch_state_t   state_nxt;
    logic           req_en;
    logic [M-1:0]   pc;
    logic           pc_inc;
    logic           pc_load;
    logic           capture;
    logic           retire;

    pc_counter #(
        .M        (M),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .inc    (pc_inc),
        .load   (pc_load),
        .target (redirect_target),
        .pc     (pc)
    );

    // req_en keeps imem_req low until the first edge after reset has been released.
    assign imem_req    = (state == FETCH) && req_en;
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign halted      = (state == HALT);

    always_comb begin
        state_nxt = state;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        capture   = 1'b0;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                if (halt_in) begin
                    state_nxt = HALT;
                end else if (redirect_valid) begin
                    pc_load = 1'b1;
                end else if (imem_req && imem_ready) begin
                    capture   = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                retire = instr_ack;
                if (halt_in) begin
                    state_nxt = HALT;
                end else if (redirect_valid) begin
                    pc_load   = 1'b1;
                    state_nxt = FETCH;
                end else if (instr_ack) begin
                    state_nxt = FETCH;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            req_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            req_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= '0;
            instr_pc <= '0;
        end else if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= 32'd0;
        end else if (retire) begin
            retired_count <= retired_count + 32'd1;
        end
    end
endmodule
